// File: rtl/proj_fm_sweep_sched.sv
// proj_fm_sweep_sched: round-robin owner of the FM buffer index sweep.
// Grants one requester at a time and streams its 0..FM_BUFFER_SIZE-1 index
// sequence over valid/ready. Each sweep ends with a one-cycle done pulse,
// which is qualified by done_abort. Priority then rotates past the last owner.
// Ports:
//   in_clk, in_rst   clock, synchronous active-high reset
//   req              per-requester sweep request (level, sampled only in IDLE)
//   abort            terminate the current sweep (ignored outside SWEEP)
//   grant, grant_id  one-hot / binary owner of the current sweep
//   idx_valid, idx_ready, index, idx_last   index stream
//   done, done_abort sweep-ended pulse and its abort qualifier
//   busy             high in SWEEP and DONE
module proj_fm_sweep_sched #(
  parameter int unsigned FM_BUFFER_SIZE = 64,
  parameter int unsigned NUM_REQ        = 4,
  localparam int unsigned IDX_W         = $clog2(FM_BUFFER_SIZE),
  localparam int unsigned ID_W          = $clog2(NUM_REQ)
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               abort,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               idx_valid,
  input  logic               idx_ready,
  output logic [IDX_W-1:0]   index,
  output logic               idx_last,
  output logic               done,
  output logic               done_abort,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FM_BUFFER_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     rr, rr_d;
  logic [NUM_REQ-1:0]  grant_d;
  logic [ID_W-1:0]     grant_id_d;
  logic [IDX_W-1:0]    index_d;
  logic                done_d, done_abort_d;
  logic                xfer;
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  int unsigned         cand;

  // First requesting bit at or above the rr pointer, wrapping around.
  always_comb begin : rr_pick
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr) + i) % NUM_REQ;
      if (!pick_found && req[ID_W'(cand)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(cand);
      end
    end
  end

  assign xfer = idx_valid & idx_ready;

  // Next-state and next-output logic.
  always_comb begin : next_logic
    state_d      = state;
    rr_d         = rr;
    grant_d      = grant;
    grant_id_d   = grant_id;
    index_d      = index;
    done_d       = 1'b0;
    done_abort_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_SWEEP;
          grant_d    = NUM_REQ'(1) << pick_id;
          grant_id_d = pick_id;
          index_d    = '0;
        end
      end
      S_SWEEP: begin
        // A last-beat transfer takes priority over a simultaneous abort.
        if (xfer && (index == LAST_IDX)) begin
          state_d = S_DONE;
          index_d = '0;
          grant_d = '0;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d      = S_DONE;
          index_d      = '0;
          grant_d      = '0;
          done_d       = 1'b1;
          done_abort_d = 1'b1;
        end else if (xfer) begin
          index_d = index + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = ID_W'((32'(grant_id) + 32'd1) % NUM_REQ);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; stream flags derive from the next state.
  always_ff @(posedge in_clk) begin : regs
    if (in_rst) begin
      state      <= S_IDLE;
      rr         <= '0;
      grant      <= '0;
      grant_id   <= '0;
      idx_valid  <= 1'b0;
      index      <= '0;
      idx_last   <= 1'b0;
      done       <= 1'b0;
      done_abort <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      rr         <= rr_d;
      grant      <= grant_d;
      grant_id   <= grant_id_d;
      idx_valid  <= (state_d == S_SWEEP);
      index      <= index_d;
      idx_last   <= (state_d == S_SWEEP) && (index_d == LAST_IDX);
      done       <= done_d;
      done_abort <= done_abort_d;
      busy       <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_proj_fm_sweep_sched.sv
// tb_proj_fm_sweep_sched: randomized self-checking bench for proj_fm_sweep_sched.
// A transaction-level model (rr pointer plus a round-robin pick rule) predicts
// the owner, beat sequence, end type and priority rotation of each sweep.
module tb_proj_fm_sweep_sched;

  localparam int SIZE = 64;
  localparam int NREQ = 4;
  localparam int IDXW = 6;
  localparam int IDW  = 2;

  logic            clk;
  logic            in_rst;
  logic [NREQ-1:0] req;
  logic            abort;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            idx_valid;
  logic            idx_ready;
  logic [IDXW-1:0] index;
  logic            idx_last;
  logic            done;
  logic            done_abort;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int model_rr = 0;

  proj_fm_sweep_sched #(.FM_BUFFER_SIZE(SIZE), .NUM_REQ(NREQ)) dut (
    .in_clk(clk), .in_rst(in_rst), .req(req), .abort(abort),
    .grant(grant), .grant_id(grant_id), .idx_valid(idx_valid),
    .idx_ready(idx_ready), .index(index), .idx_last(idx_last),
    .done(done), .done_abort(done_abort), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first set request at or after the pointer, with wrap.
  function automatic int pick(input logic [NREQ-1:0] r, input int rr);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(rr + i) % NREQ]) return (rr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    in_rst = 1'b1; req = '0; abort = 1'b0; idx_ready = 1'b0;
    step(); step();
    in_rst = 1'b0;
    model_rr = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (grant !== '0 || grant_id !== '0 || idx_valid !== 1'b0 || index !== '0 ||
        idx_last !== 1'b0 || done !== 1'b0 || done_abort !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: grant=%b id=%0d v=%b idx=%0d last=%b done=%b ab=%b busy=%b, required all zero",
               grant, grant_id, idx_valid, index, idx_last, done, done_abort, busy);
    end
    // abort with no sweep in progress must have no effect
    abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || idx_valid !== 1'b0 || grant !== '0) begin
        failures++;
        $display("FAIL abort_idle: busy=%b done=%b valid=%b grant=%b, required 0/0/0/0",
                 busy, done, idx_valid, grant);
      end
    end
    abort = 1'b0;
  endtask

  // One complete sweep: request, beats with random backpressure, optional
  // abort when the expected index equals abort_idx, then done and idle.
  task automatic run_sweep(input logic [NREQ-1:0] r, input bit hold_req,
                           input int ready_pct, input int abort_idx);
    int exp_id;
    logic [NREQ-1:0] exp_g;
    int exp_idx;
    int beats;
    int budget;
    bit ended;
    bit exp_ab;
    bit rdy;
    bit ab;
    exp_id  = pick(r, model_rr);
    exp_g   = NREQ'(1) << exp_id;
    exp_idx = 0;
    beats   = 0;
    budget  = 0;
    ended   = 1'b0;
    exp_ab  = 1'b0;
    req = r;
    step();
    checks++;
    if (grant !== exp_g || grant_id !== IDW'(exp_id) || idx_valid !== 1'b1 ||
        index !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL grant_start: grant=%b id=%0d v=%b idx=%0d busy=%b, required grant=%b id=%0d v=1 idx=0 busy=1",
               grant, grant_id, idx_valid, index, busy, exp_g, exp_id);
    end
    if (!hold_req) req = '0;
    while (!ended && budget < 2000) begin
      checks++;
      if (idx_valid !== 1'b1 || grant !== exp_g || index !== IDXW'(exp_idx) ||
          idx_last !== (exp_idx == SIZE - 1) || done !== 1'b0) begin
        failures++;
        $display("FAIL beat: v=%b grant=%b idx=%0d last=%b done=%b, required v=1 grant=%b idx=%0d last=%b done=0",
                 idx_valid, grant, index, idx_last, done, exp_g, exp_idx, (exp_idx == SIZE - 1));
      end
      rdy = ($urandom_range(99) < ready_pct);
      ab  = (exp_idx == abort_idx);
      idx_ready = rdy;
      abort     = ab;
      step();
      idx_ready = 1'b0;
      abort     = 1'b0;
      if (rdy) begin
        beats++;
        if (exp_idx == SIZE - 1) ended = 1'b1;
        else exp_idx++;
      end
      if (!ended && ab) begin
        ended  = 1'b1;
        exp_ab = 1'b1;
      end
      budget++;
    end
    if (!ended) begin
      checks++;
      failures++;
      $display("FAIL sweep_timeout: sweep still running after %0d cycles, required completion", budget);
    end
    checks++;
    if (done !== 1'b1 || done_abort !== exp_ab || grant !== '0 || idx_valid !== 1'b0 ||
        idx_last !== 1'b0 || busy !== 1'b1 || index !== '0) begin
      failures++;
      $display("FAIL done_pulse: done=%b ab=%b grant=%b v=%b last=%b busy=%b idx=%0d, required 1/%b/0/0/0/1/0",
               done, done_abort, grant, idx_valid, idx_last, busy, index, exp_ab);
    end
    if (!exp_ab) begin
      checks++;
      if (beats != SIZE) begin
        failures++;
        $display("FAIL beat_count: got %0d beats, required %0d", beats, SIZE);
      end
    end
    model_rr = (exp_id + 1) % NREQ;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || idx_valid !== 1'b0 || grant !== '0) begin
      failures++;
      $display("FAIL post_done_idle: done=%b busy=%b v=%b grant=%b, required 0/0/0/0",
               done, busy, idx_valid, grant);
    end
  endtask

  task automatic test_single();
    run_sweep(4'b0010, 1'b0, 100, -1);
  endtask

  task automatic test_backpressure();
    run_sweep(4'b0010, 1'b0, 45, -1);
    run_sweep(4'b1001, 1'b0, 70, -1);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 5; k++) run_sweep(4'b1111, 1'b1, 100, -1);
  endtask

  task automatic test_abort();
    run_sweep(4'b1111, 1'b0, 100, 10);
    run_sweep(4'b1111, 1'b0, 100, -1);
    run_sweep(4'b0110, 1'b0, 100, SIZE - 1);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    int ab_idx;
    for (int k = 0; k < 10; k++) begin
      r      = NREQ'($urandom_range(1, 15));
      ab_idx = ($urandom_range(99) < 35) ? $urandom_range(0, SIZE - 1) : -1;
      run_sweep(r, 1'($urandom_range(1)), $urandom_range(30, 100), ab_idx);
    end
  endtask

  task automatic test_mid_reset();
    int budget;
    run_sweep(4'b0001, 1'b0, 100, -1);
    req = 4'b0100;
    step();
    req = '0;
    idx_ready = 1'b1;
    budget = 0;
    while (index !== IDXW'(20) && budget < 200) begin
      step();
      budget++;
    end
    checks++;
    if (index !== IDXW'(20) || idx_valid !== 1'b1) begin
      failures++;
      $display("FAIL reach_idx20: idx=%0d v=%b, required idx=20 v=1", index, idx_valid);
    end
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    idx_ready = 1'b0;
    checks++;
    if (grant !== '0 || grant_id !== '0 || idx_valid !== 1'b0 || index !== '0 ||
        idx_last !== 1'b0 || done !== 1'b0 || done_abort !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_values: grant=%b id=%0d v=%b idx=%0d last=%b done=%b ab=%b busy=%b, required all zero",
               grant, grant_id, idx_valid, index, idx_last, done, done_abort, busy);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || idx_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL no_done_after_reset: done=%b v=%b busy=%b, required 0/0/0", done, idx_valid, busy);
      end
    end
    model_rr = 0;
    run_sweep(4'b1111, 1'b0, 100, -1);
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_abort();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/proj_fm_sweep_sched.md
# proj_fm_sweep_sched

Round-robin scheduler that shares the FM buffer index sweep between several requesters. It grants one requester at a time and drives the granted client's full 0..FM_BUFFER_SIZE-1 index sequence over a valid/ready stream. It reports completion or abort, then rotates priority. It sits between the FM buffer clients (sorter, extender read stage) and the FM buffer read port.

## Interface
- FM_BUFFER_SIZE, 64: entries per FM buffer, ≥2; index width IDX_W = $clog2(FM_BUFFER_SIZE).
- NUM_REQ, 4: number of requesters, 2..8; ID_W = $clog2(NUM_REQ).
- in_clk  input  1  clock; all logic on rising edge.
- in_rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester sweep request (level).
- abort  input  1  terminate current sweep.
- grant  output  NUM_REQ  one-hot owner of current sweep; all zero when not in SWEEP.
- grant_id  output  ID_W  binary form of grant; valid while busy.
- idx_valid  output  1  index beat valid.
- idx_ready  input  1  downstream accepts beat.
- index  output  IDX_W  current FM buffer index.
- idx_last  output  1  beat carries index FM_BUFFER_SIZE-1.
- done  output  1  one-cycle pulse, sweep ended.
- done_abort  output  1  qualifies done: 1 = ended by abort.
- busy  output  1  high in SWEEP and DONE.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- Reset values: state IDLE, rr pointer 0, grant 0, grant_id 0, idx_valid 0, index 0, idx_last 0, done 0, done_abort 0, busy 0.
- IDLE: if any req bit set, pick the first set bit at or after rr pointer, searching upward with wrap. Register grant/grant_id, set index=0, go to SWEEP. Otherwise stay.
- SWEEP: idx_valid=1, grant held. A beat transfers when idx_valid && idx_ready. On transfer, index increments by 1. index/idx_last are stable while idx_ready is low.
- Last beat: a transfer with index==FM_BUFFER_SIZE-1 moves to DONE with done_abort=0. index wraps to 0, never to FM_BUFFER_SIZE.
- abort in SWEEP with no last-beat transfer that cycle: go to DONE with done_abort=1. index resets to 0.
- abort in the same cycle as the last-beat transfer: the completion wins, done_abort=0.
- abort outside SWEEP is ignored.
- DONE, one cycle: done=1, grant=0, idx_valid=0, busy=1. rr pointer ← (grant_id+1) mod NUM_REQ. Next state IDLE.
- Once a sweep starts, req is not sampled. Deasserting the owner's req mid-sweep does not stop the sweep; only abort does.
- in_rst asserted in any state returns all state to reset values on the next edge. No done pulse is produced for an interrupted sweep.

## Timing
- req high in IDLE at edge N: grant, idx_valid=1 and index=0 are visible after edge N (cycle N+1).
- Full sweep with idx_ready held high: FM_BUFFER_SIZE beats on consecutive cycles.
- done pulses the cycle after the last transfer or the abort. IDLE follows one cycle later.
- Minimum gap from the last beat of one sweep to index 0 of the next: 2 idle cycles. The stream is low during DONE and IDLE.
- All outputs are registered. No combinational path from idx_ready or req to any output.
- idx_last = idx_valid && index==FM_BUFFER_SIZE-1.

## Test plan
- Single requester: reset, req=4'b0010, idx_ready=1.
  - Expect grant=0010 one cycle after req, and 64 beats with index 0..63.
  - Expect idx_last only on 63, then done=1 with done_abort=0 on the next cycle.
  - Expect grant=0 during done.
- Backpressure: toggle idx_ready randomly.
  - Expect no index skipped or repeated, and index held while ready=0.
  - Beat count is exactly 64.
- Round robin: req=4'b1111 held.
  - Expect successive grants 0001, 0010, 0100, 1000, 0001.
  - Expect a 2-cycle stream gap between sweeps.
- Abort at index 10 (ready=1):
  - Expect done=1 with done_abort=1 on the next cycle, and no idx_valid afterwards.
  - Next grant goes to the following requester.
- Abort together with the index-63 transfer: expect done=1 with done_abort=0.
- Mid-sweep reset at index 20:
  - Expect all outputs at reset values after the next edge, and no done pulse.
  - The next sweep is granted from rr pointer 0.
